// File: rtl/rv_pipe_ctrl_hazard_if.sv
// ID-stage instruction fields in; pipeline control, forwarding and hazard controls out.
interface rv_pipe_ctrl_hazard_if #(
  parameter int unsigned RA_W = 5
);
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [RA_W-1:0] rs1_D;
  logic [RA_W-1:0] rs2_D;
  logic [RA_W-1:0] rd_D;
  logic            Zero_E;
  logic [1:0]      ImmSrc_D;
  logic [3:0]      ALUControl_E;
  logic            ALUSrc_E;
  logic            MemWrite_M;
  logic            RegWrite_W;
  logic [1:0]      ResultSrc_W;
  logic            PCSrc_E;
  logic [1:0]      ForwardA_E;
  logic [1:0]      ForwardB_E;
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;

  modport master (
    output op, funct3, funct7b5, rs1_D, rs2_D, rd_D, Zero_E,
    input  ImmSrc_D, ALUControl_E, ALUSrc_E, MemWrite_M, RegWrite_W, ResultSrc_W,
           PCSrc_E, ForwardA_E, ForwardB_E, StallF, StallD, FlushD, FlushE
  );

  modport slave (
    input  op, funct3, funct7b5, rs1_D, rs2_D, rd_D, Zero_E,
    output ImmSrc_D, ALUControl_E, ALUSrc_E, MemWrite_M, RegWrite_W, ResultSrc_W,
           PCSrc_E, ForwardA_E, ForwardB_E, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/rv_pipe_ctrl_hazard.sv
// Five-stage RV32I control unit: ID decode, E/M/W control pipeline, forwarding and hazard logic.
module rv_pipe_ctrl_hazard #(
  parameter int unsigned RA_W       = 5,
  parameter bit          ENABLE_FWD = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  rv_pipe_ctrl_hazard_if.slave bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } ctrl_de_t;

  ctrl_de_t        dec_c, de_d, de_q;
  logic [1:0]      imm_src_c;
  logic            uses_rs1_c, uses_rs2_c;
  logic [3:0]      alu_funct_c;
  logic            reg_write_m_d, reg_write_m_q;
  logic [1:0]      result_src_m_d, result_src_m_q;
  logic            mem_write_m_d, mem_write_m_q;
  logic [RA_W-1:0] rd_m_d, rd_m_q;
  logic            reg_write_w_d, reg_write_w_q;
  logic [1:0]      result_src_w_d, result_src_w_q;
  logic [RA_W-1:0] rd_w_d, rd_w_q;
  logic            pc_src_c, hazard_c, flush_e_c;
  logic [1:0]      fwd_a_c, fwd_b_c;

  // ALU operation selected by funct3/funct7b5 (R-type and I-ALU)
  always_comb begin
    alu_funct_c = ALU_ADD;
    case (bus.funct3)
      3'b000: alu_funct_c = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_funct_c = ALU_SLL;
      3'b010: alu_funct_c = ALU_SLT;
      3'b011: alu_funct_c = ALU_SLTU;
      3'b100: alu_funct_c = ALU_XOR;
      3'b101: alu_funct_c = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_funct_c = ALU_OR;
      3'b111: alu_funct_c = ALU_AND;
    endcase
  end

  // Opcode decode; unknown opcodes decode as a NOP
  always_comb begin
    dec_c      = '0;
    imm_src_c  = 2'b00;
    uses_rs1_c = 1'b0;
    uses_rs2_c = 1'b0;
    case (bus.op)
      OP_LW: begin
        dec_c.reg_write  = 1'b1;
        dec_c.result_src = 2'b01;
        dec_c.alu_src    = 1'b1;
        dec_c.alu_ctrl   = ALU_ADD;
        uses_rs1_c       = 1'b1;
      end
      OP_SW: begin
        dec_c.mem_write = 1'b1;
        dec_c.alu_src   = 1'b1;
        dec_c.alu_ctrl  = ALU_ADD;
        imm_src_c       = 2'b01;
        uses_rs1_c      = 1'b1;
        uses_rs2_c      = 1'b1;
      end
      OP_R: begin
        dec_c.reg_write = 1'b1;
        dec_c.alu_ctrl  = alu_funct_c;
        uses_rs1_c      = 1'b1;
        uses_rs2_c      = 1'b1;
      end
      OP_I: begin
        dec_c.reg_write = 1'b1;
        dec_c.alu_src   = 1'b1;
        dec_c.alu_ctrl  = alu_funct_c;
        uses_rs1_c      = 1'b1;
      end
      OP_BEQ: begin
        dec_c.branch   = 1'b1;
        dec_c.alu_ctrl = ALU_SUB;
        imm_src_c      = 2'b10;
        uses_rs1_c     = 1'b1;
        uses_rs2_c     = 1'b1;
      end
      OP_JAL: begin
        dec_c.reg_write  = 1'b1;
        dec_c.jump       = 1'b1;
        dec_c.result_src = 2'b10;
        imm_src_c        = 2'b11;
      end
      default: ;
    endcase
    // Unused source fields are carried as x0 so immediate bits never trigger forwarding
    dec_c.rs1 = uses_rs1_c ? bus.rs1_D : '0;
    dec_c.rs2 = uses_rs2_c ? bus.rs2_D : '0;
    dec_c.rd  = bus.rd_D;
  end

  // Forwarding selects, RAW/load-use detection and redirect
  always_comb begin
    fwd_a_c  = 2'b00;
    fwd_b_c  = 2'b00;
    hazard_c = 1'b0;
    pc_src_c = (de_q.branch & bus.Zero_E) | de_q.jump;
    if (ENABLE_FWD) begin
      if (reg_write_m_q && (rd_m_q != '0) && (rd_m_q == de_q.rs1))      fwd_a_c = 2'b10;
      else if (reg_write_w_q && (rd_w_q != '0) && (rd_w_q == de_q.rs1)) fwd_a_c = 2'b01;
      if (reg_write_m_q && (rd_m_q != '0) && (rd_m_q == de_q.rs2))      fwd_b_c = 2'b10;
      else if (reg_write_w_q && (rd_w_q != '0) && (rd_w_q == de_q.rs2)) fwd_b_c = 2'b01;
      hazard_c = (de_q.result_src == 2'b01) && (de_q.rd != '0) &&
                 ((uses_rs1_c && (bus.rs1_D == de_q.rd)) || (uses_rs2_c && (bus.rs2_D == de_q.rd)));
    end else begin
      // W needs no stall: the register file writes on the falling edge
      hazard_c = (de_q.reg_write && (de_q.rd != '0) &&
                  ((uses_rs1_c && (bus.rs1_D == de_q.rd)) || (uses_rs2_c && (bus.rs2_D == de_q.rd)))) ||
                 (reg_write_m_q && (rd_m_q != '0) &&
                  ((uses_rs1_c && (bus.rs1_D == rd_m_q)) || (uses_rs2_c && (bus.rs2_D == rd_m_q))));
    end
    flush_e_c = hazard_c | pc_src_c;
  end

  // Next-state for the control pipeline; a flush bubbles D->E
  always_comb begin
    de_d           = flush_e_c ? '0 : dec_c;
    reg_write_m_d  = de_q.reg_write;
    result_src_m_d = de_q.result_src;
    mem_write_m_d  = de_q.mem_write;
    rd_m_d         = de_q.rd;
    reg_write_w_d  = reg_write_m_q;
    result_src_w_d = result_src_m_q;
    rd_w_d         = rd_m_q;
  end

  // Pipeline control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q           <= '0;
      reg_write_m_q  <= 1'b0;
      result_src_m_q <= 2'b00;
      mem_write_m_q  <= 1'b0;
      rd_m_q         <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
      rd_w_q         <= '0;
    end else begin
      de_q           <= de_d;
      reg_write_m_q  <= reg_write_m_d;
      result_src_m_q <= result_src_m_d;
      mem_write_m_q  <= mem_write_m_d;
      rd_m_q         <= rd_m_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
    end
  end

  assign bus.ImmSrc_D     = imm_src_c;
  assign bus.ALUControl_E = de_q.alu_ctrl;
  assign bus.ALUSrc_E     = de_q.alu_src;
  assign bus.MemWrite_M   = mem_write_m_q;
  assign bus.RegWrite_W   = reg_write_w_q;
  assign bus.ResultSrc_W  = result_src_w_q;
  assign bus.PCSrc_E      = pc_src_c;
  assign bus.ForwardA_E   = fwd_a_c;
  assign bus.ForwardB_E   = fwd_b_c;
  // A redirect overrides a coincident stall
  assign bus.StallF       = hazard_c & ~pc_src_c;
  assign bus.StallD       = hazard_c & ~pc_src_c;
  assign bus.FlushD       = pc_src_c;
  assign bus.FlushE       = flush_e_c;
endmodule

// File: tb/tb_rv_pipe_ctrl_hazard.sv
// Directed bench for rv_pipe_ctrl_hazard, forwarding and stall-only builds, with a per-cycle scoreboard.
module tb_rv_pipe_ctrl_hazard;
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic [15:0] tag;
    logic [1:0]  imm;
    logic [3:0]  aluc;
    logic        alusrc;
    logic        memw;
    logic        regw;
    logic [1:0]  ress;
    logic        pcsrc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        sf;
    logic        sd;
    logic        fd;
    logic        fe;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rv_pipe_ctrl_hazard_if #(.RA_W(5)) if1 ();
  rv_pipe_ctrl_hazard_if #(.RA_W(5)) if0 ();

  rv_pipe_ctrl_hazard #(.RA_W(5), .ENABLE_FWD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  rv_pipe_ctrl_hazard #(.RA_W(5), .ENABLE_FWD(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

  exp_t q1[$];
  exp_t q0[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  // I-ALU / R-type sweep table: funct3, funct7b5, is-immediate, expected ALUControl
  logic [2:0] sw_f3  [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0, 3'd5, 3'd0};
  logic       sw_f7  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       sw_isi [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0] sw_alu [11] = '{4'h6, 4'h5, 4'h9, 4'h4, 4'h7, 4'h8, 4'h3, 4'h2, 4'h0, 4'h8, 4'h1};

  function automatic instr_t mk_ins(input int op, input int f3, input int f7,
                                    input int rd, input int rs1, input int rs2);
    instr_t i;
    i.op = 7'(op); i.f3 = 3'(f3); i.f7 = 1'(f7);
    i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    return i;
  endfunction

  function automatic instr_t ins_nop();
    return mk_ins(0, 0, 0, 0, 0, 0);
  endfunction
  function automatic instr_t ins_r(input int f3, input int f7, input int rd, input int rs1, input int rs2);
    return mk_ins(7'b0110011, f3, f7, rd, rs1, rs2);
  endfunction
  function automatic instr_t ins_i(input int f3, input int f7, input int rd, input int rs1, input int rs2f);
    return mk_ins(7'b0010011, f3, f7, rd, rs1, rs2f);
  endfunction
  function automatic instr_t ins_lw(input int rd, input int rs1);
    return mk_ins(7'b0000011, 2, 0, rd, rs1, 0);
  endfunction
  function automatic instr_t ins_sw(input int rs2, input int rs1);
    return mk_ins(7'b0100011, 2, 0, 0, rs1, rs2);
  endfunction
  function automatic instr_t ins_beq(input int rs1, input int rs2);
    return mk_ins(7'b1100011, 0, 0, 0, rs1, rs2);
  endfunction
  function automatic instr_t ins_jal(input int rd, input int rs1f);
    return mk_ins(7'b1101111, 0, 0, rd, rs1f, 0);
  endfunction

  // Expected outputs: imm, aluc, alusrc, memw, regw, ress, pcsrc, fa, fb, stall, flushD, flushE
  function automatic exp_t mk(input int imm, input int aluc, input int alusrc, input int memw,
                              input int regw, input int ress, input int pcsrc, input int fa,
                              input int fb, input int stall, input int fd, input int fe);
    exp_t e;
    e.tag = '0;
    e.imm = 2'(imm); e.aluc = 4'(aluc); e.alusrc = 1'(alusrc); e.memw = 1'(memw);
    e.regw = 1'(regw); e.ress = 2'(ress); e.pcsrc = 1'(pcsrc);
    e.fa = 2'(fa); e.fb = 2'(fb); e.sf = 1'(stall); e.sd = 1'(stall);
    e.fd = 1'(fd); e.fe = 1'(fe);
    return e;
  endfunction

  function automatic exp_t z0();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string d, input int tag, input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d %s: got %0h, expected %0h", d, tag, name, act, exp);
    end
  endtask

  task automatic cmp_rec(input string d, input exp_t e, input exp_t a);
    chk(d, int'(e.tag), "ImmSrc_D",     4'(a.imm),    4'(e.imm));
    chk(d, int'(e.tag), "ALUControl_E", a.aluc,       e.aluc);
    chk(d, int'(e.tag), "ALUSrc_E",     4'(a.alusrc), 4'(e.alusrc));
    chk(d, int'(e.tag), "MemWrite_M",   4'(a.memw),   4'(e.memw));
    chk(d, int'(e.tag), "RegWrite_W",   4'(a.regw),   4'(e.regw));
    chk(d, int'(e.tag), "ResultSrc_W",  4'(a.ress),   4'(e.ress));
    chk(d, int'(e.tag), "PCSrc_E",      4'(a.pcsrc),  4'(e.pcsrc));
    chk(d, int'(e.tag), "ForwardA_E",   4'(a.fa),     4'(e.fa));
    chk(d, int'(e.tag), "ForwardB_E",   4'(a.fb),     4'(e.fb));
    chk(d, int'(e.tag), "StallF",       4'(a.sf),     4'(e.sf));
    chk(d, int'(e.tag), "StallD",       4'(a.sd),     4'(e.sd));
    chk(d, int'(e.tag), "FlushD",       4'(a.fd),     4'(e.fd));
    chk(d, int'(e.tag), "FlushE",       4'(a.fe),     4'(e.fe));
  endtask

  // Monitor: one expected record per cycle, compared at the falling edge
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = '0;
      a.imm = if1.ImmSrc_D; a.aluc = if1.ALUControl_E; a.alusrc = if1.ALUSrc_E;
      a.memw = if1.MemWrite_M; a.regw = if1.RegWrite_W; a.ress = if1.ResultSrc_W;
      a.pcsrc = if1.PCSrc_E; a.fa = if1.ForwardA_E; a.fb = if1.ForwardB_E;
      a.sf = if1.StallF; a.sd = if1.StallD; a.fd = if1.FlushD; a.fe = if1.FlushE;
      cmp_rec("fwd1", e, a);
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = '0;
      a.imm = if0.ImmSrc_D; a.aluc = if0.ALUControl_E; a.alusrc = if0.ALUSrc_E;
      a.memw = if0.MemWrite_M; a.regw = if0.RegWrite_W; a.ress = if0.ResultSrc_W;
      a.pcsrc = if0.PCSrc_E; a.fa = if0.ForwardA_E; a.fb = if0.ForwardB_E;
      a.sf = if0.StallF; a.sd = if0.StallD; a.fd = if0.FlushD; a.fe = if0.FlushE;
      cmp_rec("fwd0", e, a);
    end
  end

  // Drive one cycle of ID-stage input on the selected DUT and queue its expected outputs
  task automatic step(input bit which, input logic rst, input instr_t in, input logic zero, input exp_t e);
    @(posedge clk);
    #1;
    reset = rst;
    n_step++;
    e.tag = 16'(n_step);
    if (which) begin
      if1.op = in.op; if1.funct3 = in.f3; if1.funct7b5 = in.f7;
      if1.rs1_D = in.rs1; if1.rs2_D = in.rs2; if1.rd_D = in.rd; if1.Zero_E = zero;
      q1.push_back(e);
    end else begin
      if0.op = in.op; if0.funct3 = in.f3; if0.funct7b5 = in.f7;
      if0.rs1_D = in.rs1; if0.rs2_D = in.rs2; if0.rd_D = in.rd; if0.Zero_E = zero;
      q0.push_back(e);
    end
  endtask

  initial begin
    exp_t   e;
    instr_t in;
    if1.op = '0; if1.funct3 = '0; if1.funct7b5 = 1'b0; if1.rs1_D = '0; if1.rs2_D = '0; if1.rd_D = '0; if1.Zero_E = 1'b0;
    if0.op = '0; if0.funct3 = '0; if0.funct7b5 = 1'b0; if0.rs1_D = '0; if0.rs2_D = '0; if0.rd_D = '0; if0.Zero_E = 1'b0;

    // Reset state
    step(1, 1, ins_nop(), 0, z0());

    // ALU dependency back-to-back (M forward), then with one NOP gap (W forward)
    step(1, 0, ins_r(0, 0, 5, 1, 2), 0, z0());
    step(1, 0, ins_r(0, 1, 6, 5, 3), 0, z0());
    step(1, 0, ins_nop(), 0, mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_r(0, 0, 5, 1, 2), 0, z0());
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_r(0, 1, 6, 5, 3), 0, z0());
    step(1, 0, ins_nop(), 0, mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());

    // Load-use: one stall cycle, add held in D, then W forward
    step(1, 0, ins_lw(5, 1), 0, z0());
    step(1, 0, ins_r(0, 0, 6, 5, 2), 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(1, 0, ins_r(0, 0, 6, 5, 2), 0, z0());
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());

    // Branch taken: wrong-path sw becomes a bubble, never writes memory
    step(1, 0, ins_beq(1, 2), 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_sw(9, 1), 1, mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_nop(), 0, z0());
    // Branch not taken: sw proceeds and writes in M
    step(1, 0, ins_beq(1, 2), 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_sw(9, 1), 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());

    // x0 never forwards; unused rs2 field of addi matches a load but neither stalls nor forwards
    step(1, 0, ins_r(0, 0, 0, 1, 2), 0, z0());
    step(1, 0, ins_r(0, 0, 3, 0, 0), 0, z0());
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_lw(5, 1), 0, z0());
    step(1, 0, ins_i(0, 0, 6, 7, 5), 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());

    // Reset asserted during a load-use stall
    step(1, 0, ins_lw(5, 1), 0, z0());
    step(1, 0, ins_r(0, 0, 6, 5, 2), 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(1, 1, ins_r(0, 0, 6, 5, 2), 0, z0());
    step(1, 1, ins_r(0, 0, 6, 5, 2), 0, z0());
    step(1, 0, ins_r(0, 0, 6, 5, 2), 0, z0());
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_nop(), 0, z0());
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());

    // ALU-function sweep, all rd=x0 so no hazards
    for (int k = 0; k < 14; k++) begin
      if (k < 11) in = sw_isi[k] ? ins_i(int'(sw_f3[k]), int'(sw_f7[k]), 0, 0, 0)
                                 : ins_r(int'(sw_f3[k]), int'(sw_f7[k]), 0, 0, 0);
      else        in = ins_nop();
      e = z0();
      if (k >= 1 && k <= 11) begin
        e.aluc   = sw_alu[k-1];
        e.alusrc = sw_isi[k-1];
      end
      if (k >= 3) e.regw = 1'b1;
      step(1, 0, in, 0, e);
    end

    // jal after a load: rs1 field matches the load rd but is unused
    step(1, 0, ins_lw(5, 1), 0, z0());
    step(1, 0, ins_jal(1, 5), 0, mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_sw(9, 1), 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    step(1, 0, ins_nop(), 0, z0());

    // Stall-only build: RAW in E then M stalls two cycles, selects stay 00
    step(0, 0, ins_r(0, 0, 5, 1, 2), 0, z0());
    step(0, 0, ins_r(0, 0, 6, 5, 3), 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(0, 0, ins_r(0, 0, 6, 5, 3), 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(0, 0, ins_r(0, 0, 6, 5, 3), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, ins_nop(), 0, z0());
    step(0, 0, ins_nop(), 0, z0());
    step(0, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, ins_nop(), 0, z0());
    // Producer already in W: no stall
    step(0, 0, ins_r(0, 0, 5, 1, 2), 0, z0());
    step(0, 0, ins_nop(), 0, z0());
    step(0, 0, ins_nop(), 0, z0());
    step(0, 0, ins_r(0, 0, 6, 5, 3), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, ins_nop(), 0, z0());
    step(0, 0, ins_nop(), 0, z0());
    step(0, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, ins_nop(), 0, z0());
    // Taken branch in E while D stalls on M: flush wins
    step(0, 0, ins_r(0, 0, 5, 1, 2), 0, z0());
    step(0, 0, ins_beq(1, 2), 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, ins_r(0, 0, 6, 5, 3), 1, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    step(0, 0, ins_nop(), 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, ins_nop(), 0, z0());
    step(0, 0, ins_nop(), 0, z0());

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && (q1.size() + q0.size()) > 0; i++) @(posedge clk);
    if ((q1.size() + q0.size()) > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", q1.size() + q0.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
